// File: rtl/hazard_ctrl_sb_pkg.sv
// Shared types and limits for the RV32I hazard controller with a long-latency scoreboard.
// Only types, constants and a pure helper live here; there is no state in the package.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   localparam int LOAD_STALL_MAX = 3;
   localparam int LCNT_W         = $clog2(LOAD_STALL_MAX);

   // The memory stage holds the younger result, so it beats writeback.
   function automatic fwd_sel_t fwd_pick(input logic hit_m, input logic hit_w);
      if (hit_m)      return FWD_M;
      else if (hit_w) return FWD_W;
      else            return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_ctrl_sb_scoreboard.sv
// Pending-register bitmap and in-flight count for mul/div ops; lookups are combinational.
// State updates land on the next edge; effective lookups fold in this cycle's issue and completion.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_AW  = 5,
   parameter int MAX_OUT = 4,
   parameter int CW      = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              iss_cand_i,
   input  logic              iss_en_i,
   input  logic [REG_AW-1:0] iss_rd_i,
   input  logic              done_i,
   input  logic [REG_AW-1:0] done_rd_i,
   input  logic [REG_AW-1:0] rd1_i,
   input  logic [REG_AW-1:0] rd2_i,
   input  logic [REG_AW-1:0] rd3_i,
   output logic              pend1_o,
   output logic              pend2_o,
   output logic              pend3_o,
   output logic              done_ok_o,
   output logic              err_o,
   output logic              full_o,
   output logic [CW-1:0]     cnt_o
);
   localparam int NR = 2**REG_AW;

   logic [NR-1:0] pend_q, pend_d, eff, clr_m, set_eff_m, set_st_m;
   logic [CW-1:0] cnt_q, cnt_d;

   assign done_ok_o = done_i && pend_q[done_rd_i];
   assign err_o     = done_i && !pend_q[done_rd_i];

   // The hazard view uses the issue candidate even when the E stage is being flushed,
   // which keeps the stall/flush path free of a combinational loop.
   always_comb begin
      clr_m     = '0;
      set_eff_m = '0;
      set_st_m  = '0;
      if (done_ok_o) clr_m[done_rd_i] = 1'b1;
      if (iss_cand_i) set_eff_m[iss_rd_i] = 1'b1;
      if (iss_en_i) set_st_m[iss_rd_i] = 1'b1;
      eff       = (pend_q & ~clr_m) | set_eff_m;
      eff[0]    = 1'b0;
      pend_d    = (pend_q & ~clr_m) | set_st_m;
      pend_d[0] = 1'b0;
   end

   always_comb begin
      cnt_d = cnt_q;
      case ({iss_en_i, done_ok_o})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pend1_o = eff[rd1_i];
   assign pend2_o = eff[rd2_i];
   assign pend3_o = eff[rd3_i];
   assign full_o  = (cnt_q == CW'(MAX_OUT));
   assign cnt_o   = cnt_q;

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Hazard controller: forwarding, multi-cycle load-use stall and scoreboard stalls, all combinational.
// A taken branch overrides every stall; outputs are forced low while reset is held.
module hazard_ctrl_sb
   import hazard_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int LOAD_STALL = 1,
   parameter int MAX_OUT    = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [REG_AW-1:0]              Rs1D,
   input  logic [REG_AW-1:0]              Rs2D,
   input  logic [REG_AW-1:0]              RdD,
   input  logic                           RegWriteD,
   input  logic                           MulDivD,
   input  logic [REG_AW-1:0]              Rs1E,
   input  logic [REG_AW-1:0]              Rs2E,
   input  logic [REG_AW-1:0]              RdE,
   input  logic                           RegWriteE,
   input  logic                           MulDivE,
   input  logic                           ResultSrcE_zero,
   input  logic [REG_AW-1:0]              RdM,
   input  logic                           RegWriteM,
   input  logic [REG_AW-1:0]              RdW,
   input  logic                           RegWriteW,
   input  logic                           PCSrcE,
   input  logic                           mc_done,
   input  logic [REG_AW-1:0]              mc_done_rd,
   output logic                           StallF,
   output logic                           StallD,
   output logic                           FlushD,
   output logic                           FlushE,
   output logic [1:0]                     ForwardAE,
   output logic [1:0]                     ForwardBE,
   output logic                           sb_full,
   output logic                           sb_err,
   output logic [$clog2(MAX_OUT+1)-1:0]   outstanding
);
   localparam int CW = $clog2(MAX_OUT+1);

   logic [LCNT_W-1:0] lcnt_q, lcnt_d;
   logic fwd_am, fwd_aw, fwd_bm, fwd_bw;
   fwd_sel_t fwd_a, fwd_b;
   logic ld_det, ld_stall, sb_stall, stall, flush_e;
   logic iss_cand, iss_en;
   logic p1, p2, p3, done_ok, err, full;
   logic [CW-1:0] cnt;

   always_comb begin
      fwd_am = RegWriteM && (RdM != '0) && (RdM == Rs1E);
      fwd_aw = RegWriteW && (RdW != '0) && (RdW == Rs1E);
      fwd_bm = RegWriteM && (RdM != '0) && (RdM == Rs2E);
      fwd_bw = RegWriteW && (RdW != '0) && (RdW == Rs2E);
      fwd_a  = fwd_pick(fwd_am, fwd_aw);
      fwd_b  = fwd_pick(fwd_bm, fwd_bw);
   end

   assign ld_det   = ResultSrcE_zero && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
   assign ld_stall = ld_det || (lcnt_q != '0);
   assign iss_cand = MulDivE && RegWriteE && (RdE != '0);
   assign iss_en   = iss_cand && !flush_e;

   hazard_scoreboard #(
      .REG_AW  (REG_AW),
      .MAX_OUT (MAX_OUT),
      .CW      (CW)
   ) u_sb (
      .clk        (clk),
      .reset      (reset),
      .iss_cand_i (iss_cand),
      .iss_en_i   (iss_en),
      .iss_rd_i   (RdE),
      .done_i     (mc_done),
      .done_rd_i  (mc_done_rd),
      .rd1_i      (Rs1D),
      .rd2_i      (Rs2D),
      .rd3_i      (RdD),
      .pend1_o    (p1),
      .pend2_o    (p2),
      .pend3_o    (p3),
      .done_ok_o  (done_ok),
      .err_o      (err),
      .full_o     (full),
      .cnt_o      (cnt)
   );

   assign sb_stall = p1 || p2 || (RegWriteD && p3) || (MulDivD && full && !done_ok);
   assign stall    = ld_stall || sb_stall;
   assign flush_e  = PCSrcE || stall;

   always_comb begin
      lcnt_d = lcnt_q;
      if (PCSrcE)             lcnt_d = '0;
      else if (ld_det)        lcnt_d = LCNT_W'(LOAD_STALL - 1);
      else if (lcnt_q != '0)  lcnt_d = lcnt_q - LCNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) lcnt_q <= '0;
      else       lcnt_q <= lcnt_d;
   end

   assign StallF      = !reset && stall && !PCSrcE;
   assign StallD      = !reset && stall && !PCSrcE;
   assign FlushD      = !reset && PCSrcE;
   assign FlushE      = !reset && flush_e;
   assign ForwardAE   = reset ? FWD_RF : fwd_a;
   assign ForwardBE   = reset ? FWD_RF : fwd_b;
   assign sb_full     = !reset && full;
   assign sb_err      = !reset && err;
   assign outstanding = reset ? '0 : cnt;

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Directed scenarios plus randomized traffic checked against a queue-based model of in-flight ops.
module tb_hazard_ctrl_sb;
   localparam int AW = 5;
   localparam int LS = 2;
   localparam int MO = 2;

   logic clk = 1'b0;
   logic reset;
   logic [AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, mc_done_rd;
   logic RegWriteD, MulDivD, RegWriteE, MulDivE, ResultSrcE_zero;
   logic RegWriteM, RegWriteW, PCSrcE, mc_done;
   logic StallF, StallD, FlushD, FlushE, sb_full, sb_err;
   logic [1:0] ForwardAE, ForwardBE;
   logic [$clog2(MO+1)-1:0] outstanding;

   int n_chk = 0;
   int n_fail = 0;

   // Model state: registers with an op in flight, and the last cycle still covered by a load stall.
   int q[$];
   int ld_until = -1;
   int cyc = 0;
   int e_fa, e_fb, e_sf, e_fd, e_fe, e_full, e_err, e_out;
   bit m_done_ok, m_cand, m_det, m_fe_raw;

   hazard_ctrl_sb #(.REG_AW(AW), .LOAD_STALL(LS), .MAX_OUT(MO)) dut (
      .clk(clk), .reset(reset),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .MulDivD(MulDivD),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE), .MulDivE(MulDivE),
      .ResultSrcE_zero(ResultSrcE_zero), .RdM(RdM), .RegWriteM(RegWriteM),
      .RdW(RdW), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
      .mc_done(mc_done), .mc_done_rd(mc_done_rd),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .sb_full(sb_full), .sb_err(sb_err), .outstanding(outstanding)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit inflight(int r);
      foreach (q[i]) if (q[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit eff_pend(int r);
      if (r == 0) return 1'b0;
      if (m_cand && r == int'(RdE)) return 1'b1;
      return inflight(r) && !(m_done_ok && r == int'(mc_done_rd));
   endfunction

   function automatic int fwd(int rs);
      if (RegWriteM && RdM != 0 && int'(RdM) == rs) return 2;
      if (RegWriteW && RdW != 0 && int'(RdW) == rs) return 1;
      return 0;
   endfunction

   task automatic model_eval();
      bit sb, st;
      m_done_ok = mc_done && inflight(int'(mc_done_rd));
      m_cand    = MulDivE && RegWriteE && RdE != 0;
      m_det     = ResultSrcE_zero && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      sb = eff_pend(int'(Rs1D)) || eff_pend(int'(Rs2D)) || (RegWriteD && eff_pend(int'(RdD)))
           || (MulDivD && q.size() == MO && !m_done_ok);
      st = m_det || (cyc <= ld_until) || sb;
      m_fe_raw = PCSrcE || st;
      if (reset) begin
         {e_fa, e_fb, e_sf, e_fd, e_fe, e_full, e_err, e_out} = '0;
      end else begin
         e_fa   = fwd(int'(Rs1E));
         e_fb   = fwd(int'(Rs2E));
         e_sf   = int'(st && !PCSrcE);
         e_fd   = int'(PCSrcE);
         e_fe   = int'(m_fe_raw);
         e_full = int'(q.size() == MO);
         e_err  = int'(mc_done && !inflight(int'(mc_done_rd)));
         e_out  = q.size();
      end
   endtask

   task automatic model_update();
      if (reset) begin
         q.delete();
         ld_until = -1;
      end else begin
         if (m_done_ok)
            foreach (q[i]) if (q[i] == int'(mc_done_rd)) begin q.delete(i); break; end
         if (m_cand && !m_fe_raw) q.push_back(int'(RdE));
         if (PCSrcE)     ld_until = -1;
         else if (m_det) ld_until = cyc + LS - 1;
      end
      cyc++;
   endtask

   task automatic step();
      model_eval();
      @(negedge clk);
      chk("ForwardAE", ForwardAE, e_fa);
      chk("ForwardBE", ForwardBE, e_fb);
      chk("StallF", StallF, e_sf);
      chk("StallD", StallD, e_sf);
      chk("FlushD", FlushD, e_fd);
      chk("FlushE", FlushE, e_fe);
      chk("sb_full", sb_full, e_full);
      chk("sb_err", sb_err, e_err);
      chk("outstanding", outstanding, e_out);
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      {Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, mc_done_rd} = '0;
      {RegWriteD, MulDivD, RegWriteE, MulDivE, ResultSrcE_zero} = '0;
      {RegWriteM, RegWriteW, PCSrcE, mc_done} = '0;
   endtask

   task automatic issue(input int r);
      idle();
      MulDivE = 1'b1; RegWriteE = 1'b1; RdE = AW'(r);
      step();
   endtask

   task automatic rand_inputs();
      Rs1D = AW'($urandom_range(0, 7)); Rs2D = AW'($urandom_range(0, 7));
      RdD  = AW'($urandom_range(0, 7));
      Rs1E = AW'($urandom_range(0, 7)); Rs2E = AW'($urandom_range(0, 7));
      RdE  = AW'($urandom_range(0, 7));
      RdM  = AW'($urandom_range(0, 7)); RdW  = AW'($urandom_range(0, 7));
      RegWriteD = 1'($urandom_range(0, 1)); MulDivD   = ($urandom_range(0, 3) == 0);
      RegWriteE = ($urandom_range(0, 3) != 0);
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      MulDivE = (q.size() < MO) && ($urandom_range(0, 2) == 0) && !inflight(int'(RdE));
      ResultSrcE_zero = !MulDivE && ($urandom_range(0, 4) == 0);
      PCSrcE  = ($urandom_range(0, 15) == 0);
      mc_done = ($urandom_range(0, 2) == 0);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
         mc_done_rd = AW'(q[$urandom_range(0, q.size() - 1)]);
      else
         mc_done_rd = AW'($urandom_range(0, 15));
      reset = ($urandom_range(0, 99) == 0);
   endtask

   initial begin
      idle();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;

      // Forwarding priority
      RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 5;
      #1 chk("fwdA_M", ForwardAE, 2'b10);
      RdM = 0;
      #1 chk("fwdA_W", ForwardAE, 2'b01);
      chk("fwdB_W", ForwardBE, 2'b01);
      step();

      // Load-use stall spans exactly LS cycles
      idle(); ResultSrcE_zero = 1; RdE = 7; Rs2D = 7;
      #1 chk("ld_c0_stall", StallF, 1);
      chk("ld_c0_flushE", FlushE, 1);
      step();
      ResultSrcE_zero = 0; RdE = 0;
      #1 chk("ld_c1_stall", StallD, 1);
      step();
      #1 chk("ld_c2_release", StallF, 0);
      step();

      // RAW on a mul result, released in the completion cycle
      issue(9);
      idle(); Rs1D = 9;
      for (int i = 0; i < 3; i++) begin
         #1 chk("mul_raw_stall", StallD, 1);
         chk("mul_out1", outstanding, 1);
         step();
      end
      mc_done = 1; mc_done_rd = 9;
      #1 chk("mul_done_nostall", StallD, 0);
      chk("mul_done_out", outstanding, 1);
      step();
      mc_done = 0;
      #1 chk("mul_out0", outstanding, 0);
      step();

      // Outstanding limit, relieved by a same-cycle completion
      issue(3);
      issue(4);
      idle(); MulDivD = 1; RegWriteD = 1; RdD = 10;
      #1 chk("full_flag", sb_full, 1);
      chk("full_stall", StallF, 1);
      step();
      mc_done = 1; mc_done_rd = 3;
      #1 chk("full_relief", StallF, 0);
      step();
      idle(); mc_done = 1; mc_done_rd = 4;
      step();

      // Taken branch overrides scoreboard and load stalls and clears lcnt
      issue(6);
      idle(); Rs1D = 6; ResultSrcE_zero = 1; RdE = 11; Rs2D = 11; PCSrcE = 1;
      #1 chk("br_stallF", StallF, 0);
      chk("br_stallD", StallD, 0);
      chk("br_flushD", FlushD, 1);
      chk("br_flushE", FlushE, 1);
      step();
      idle();
      #1 chk("br_lcnt_clear", StallF, 0);
      step();
      mc_done = 1; mc_done_rd = 6;
      step();

      // Spurious completion and reset with ops in flight
      idle(); mc_done = 1; mc_done_rd = 12;
      #1 chk("err_pulse", sb_err, 1);
      chk("err_out", outstanding, 0);
      step();
      idle();
      #1 chk("err_once", sb_err, 0);
      issue(1);
      issue(2);
      idle();
      #1 chk("pre_rst_out", outstanding, 2);
      reset = 1;
      step();
      reset = 0; mc_done = 1; mc_done_rd = 1; Rs1D = 2;
      #1 chk("rst_out", outstanding, 0);
      chk("rst_err", sb_err, 1);
      chk("rst_nostall", StallF, 0);
      step();

      for (int i = 0; i < 1500; i++) begin
         rand_inputs();
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
